// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-flop synchronizer, counting debouncer,
// registered edge pulses and a clearable sticky "was pressed" flag.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btnRaw,
    input  logic [NUM_BTN-1:0] clearSticky,
    output logic [NUM_BTN-1:0] btnLevel,
    output logic [NUM_BTN-1:0] btnRise,
    output logic [NUM_BTN-1:0] btnFall,
    output logic [NUM_BTN-1:0] btnSticky
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, PENDING} state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          sync1_q, sync2_q;
        logic          level_q, level_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          sticky_q, sticky_d;
        logic          diff, done;

        // cnt_q is 0 in STABLE, so cnt_q + 1 also yields the entry value of 1
        always_comb begin
            diff     = sync2_q != level_q;
            done     = state_q == PENDING && diff && cnt_q == CNT_MAX;
            state_d  = diff && !done ? PENDING : STABLE;
            cnt_d    = diff && !done ? cnt_q + CW'(1) : '0;
            level_d  = level_q ^ done;
            rise_d   = done && !level_q;
            fall_d   = done && level_q;
            sticky_d = rise_q || (sticky_q && !clearSticky[i]);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= STABLE;
                cnt_q    <= '0;
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                sync1_q  <= btnRaw[i];
                sync2_q  <= sync1_q;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                sticky_q <= sticky_d;
            end
        end

        assign btnLevel[i]  = level_q;
        assign btnRise[i]   = rise_q;
        assign btnFall[i]   = fall_q;
        assign btnSticky[i] = sticky_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus, run-length reference model checked
// every cycle, plus hand-computed checkpoints for the documented scenarios.
module tb_button_conditioner;
    localparam int N = 3;
    localparam int D = 4;

    logic         clk = 0;
    logic         rst;
    logic [N-1:0] btnRaw, clearSticky;
    logic [N-1:0] btnLevel, btnRise, btnFall, btnSticky;

    int n_chk  = 0;
    int n_fail = 0;

    button_conditioner #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .btnRaw(btnRaw), .clearSticky(clearSticky),
        .btnLevel(btnLevel), .btnRise(btnRise), .btnFall(btnFall), .btnSticky(btnSticky)
    );

    always #5 clk = ~clk;

    // Model: a channel's level flips once the synchronized sample has disagreed
    // with it for D consecutive edges.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_stk;
    int           run [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_stk = '0;
            for (int c = 0; c < N; c++) run[c] = 0;
        end else begin
            m_stk = m_rise | (m_stk & ~clearSticky);
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                run[c] = (m_s2[c] != m_lvl[c]) ? run[c] + 1 : 0;
                if (run[c] == D) begin
                    if (m_lvl[c]) m_fall[c] = 1'b1;
                    else m_rise[c] = 1'b1;
                    m_lvl[c] = ~m_lvl[c];
                    run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btnRaw;
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    int rise_cnt1 = 0;

    initial forever begin
        @(negedge clk);
        #1;
        chk("model_level", btnLevel, m_lvl);
        chk("model_rise", btnRise, m_rise);
        chk("model_fall", btnFall, m_fall);
        chk("model_sticky", btnSticky, m_stk);
        if (btnRise[1]) rise_cnt1++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; btnRaw = '0; clearSticky = '0;
        step(3);
        chk("reset_level", btnLevel, 3'b000);
        chk("reset_sticky", btnSticky, 3'b000);
        rst = 0;
        step(2);
        // clean press on channel 0
        btnRaw = 3'b001;
        step(5);
        chk("press_early", btnLevel, 3'b000);
        step(1);
        chk("press_level", btnLevel, 3'b001);
        chk("press_rise", btnRise, 3'b001);
        step(1);
        chk("press_rise_end", btnRise, 3'b000);
        chk("press_sticky", btnSticky, 3'b001);
        // sticky clear
        clearSticky = 3'b001;
        step(1);
        clearSticky = 3'b000;
        chk("sticky_cleared", btnSticky, 3'b000);
        // release, then press again with clear overlapping the rise pulse
        btnRaw = 3'b000;
        step(8);
        chk("release0_level", btnLevel, 3'b000);
        btnRaw = 3'b001;
        step(5);
        clearSticky = 3'b001;
        step(2);
        clearSticky = 3'b000;
        chk("sticky_set_wins", btnSticky, 3'b001);
        step(2);
        // bounce on channel 1
        btnRaw = 3'b011;
        step(3);
        btnRaw = 3'b001;
        step(1);
        btnRaw = 3'b011;
        step(5);
        chk("bounce_early", btnLevel, 3'b001);
        step(1);
        chk("bounce_level", btnLevel, 3'b011);
        chk("bounce_rise", btnRise, 3'b010);
        step(2);
        chk("bounce_one_rise", 3'(rise_cnt1), 3'd1);
        // release on channel 2
        btnRaw = 3'b111;
        step(8);
        chk("ch2_high", btnLevel, 3'b111);
        btnRaw = 3'b011;
        step(6);
        chk("release_level", btnLevel, 3'b011);
        chk("release_fall", btnFall, 3'b100);
        chk("release_no_rise", btnRise, 3'b000);
        // reset mid-count
        btnRaw = 3'b000;
        step(10);
        btnRaw = 3'b001;
        step(4);
        rst = 1;
        #1;
        chk("rst_level", btnLevel, 3'b000);
        chk("rst_sticky", btnSticky, 3'b000);
        step(1);
        rst = 0;
        step(5);
        chk("post_rst_early", btnLevel, 3'b000);
        step(1);
        chk("post_rst_level", btnLevel, 3'b001);
        chk("post_rst_rise", btnRise, 3'b001);
        // simultaneous press
        btnRaw = 3'b000;
        step(10);
        btnRaw = 3'b111;
        step(6);
        chk("simul_rise", btnRise, 3'b111);
        chk("simul_level", btnLevel, 3'b111);
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 3; number of button channels (bit 0 = btnC/sigCH, bit 1 = btnU, bit 2 = btnD/sigCP).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000; consecutive stable cycles required to accept a change; legal range 2..2^24.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 btnRaw  input  NUM_BTN  raw, asynchronous, bouncing push-button pins.
REQ-006 clearSticky  input  NUM_BTN  per-channel synchronous clear of btnSticky.
REQ-007 btnLevel  output  NUM_BTN  debounced button level; feeds the IO controller switch inputs.
REQ-008 btnRise  output  NUM_BTN  one-cycle pulse when btnLevel goes 0->1.
REQ-009 btnFall  output  NUM_BTN  one-cycle pulse when btnLevel goes 1->0.
REQ-010 btnSticky  output  NUM_BTN  latched "was pressed" flag per channel.

Function
REQ-011 Each channel shall be processed independently, with no shared state between channels.
REQ-012 Each channel shall pass btnRaw through a two-flop synchronizer (sync1, sync2); only sync2 (sample s) shall be used downstream.
REQ-013 Each channel shall hold a counter of width clog2(DEBOUNCE_CYCLES+1), saturating-free, that never exceeds DEBOUNCE_CYCLES-1.
REQ-014 Each channel shall run a two-state FSM: STABLE (counter = 0, s == btnLevel) and PENDING (s != btnLevel observed, counting).
REQ-015 In STABLE, if s != btnLevel, the FSM shall go to PENDING with counter = 1; otherwise it shall stay in STABLE.
REQ-016 In PENDING, if s == btnLevel, the FSM shall return to STABLE with counter = 0 (bounce rejected, no output change).
REQ-017 In PENDING, if s != btnLevel and counter == DEBOUNCE_CYCLES-1, then on that edge btnLevel shall invert, the matching pulse (btnRise or btnFall) shall assert, counter shall clear, and the FSM shall go to STABLE.
REQ-018 In PENDING, if s != btnLevel and counter < DEBOUNCE_CYCLES-1, counter shall increment by 1.
REQ-019 Latency: if btnRaw changes and is first captured by sync1 at edge k and then held, btnLevel shall change at edge k+1+DEBOUNCE_CYCLES.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES cycles at sync2 shall produce no change on btnLevel, btnRise or btnFall.
REQ-021 btnRise and btnFall shall be registered, high for exactly one cycle, and never both high on the same channel.
REQ-022 btnSticky[i] shall be set on the edge after btnRise[i]=1 and cleared on the edge after clearSticky[i]=1; if both occur together, set wins.
REQ-023 clearSticky shall have no effect on btnLevel, counters or pulses.
REQ-024 All outputs shall come directly from flops; there shall be no combinational path from input to output.

Reset
REQ-025 While rst=1: sync1, sync2, btnLevel, btnRise, btnFall and btnSticky shall all be 0, counters 0, and the FSM in STABLE.
REQ-026 Asserting rst mid-PENDING shall discard the partial count; after release, a button still held high shall be handled as a fresh press, with full REQ-019 latency and a btnRise.
REQ-027 Deassertion of rst may be asynchronous to clk; the first post-reset edge shall treat all channels as level 0.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=3)
REQ-028 Clean press: btnRaw[0] 0->1 captured at edge k and held -> btnLevel[0]=1 and btnRise[0] one-cycle pulse at edge k+5; btnSticky[0]=1 at k+6; channels 1 and 2 unchanged.
REQ-029 Bounce: btnRaw[1] high 3 cycles, low 1, high held -> no output during the bounce; btnLevel[1] rises 5 edges after the final 0->1 capture, with exactly one btnRise[1].
REQ-030 Release: with btnLevel[2]=1, btnRaw[2] 1->0 held -> btnFall[2] pulse and btnLevel[2]=0 at capture edge +5; btnRise[2] stays 0.
REQ-031 Sticky: clearSticky[0]=1 on the same edge btnRise[0] is registered -> btnSticky[0]=1; clearSticky[0]=1 a later cycle -> btnSticky[0]=0 next edge.
REQ-032 Reset mid-count: btnRaw[0]=1 held, rst pulsed at count 2 -> all outputs 0; btnLevel[0] rises 5 edges after the post-reset sync1 capture.
REQ-033 Simultaneous: all three btnRaw rise on the same cycle -> all three btnRise pulse on the same edge, and btnLevel=3'b111.
